// File: rtl/ifetc32_mc_if.sv
// Instruction-memory request/response bundle for ifetc32_mc.
//   imem_req   : fetch request, held high while waiting for imem_ack
//   imem_addr  : byte address of the requested word
//   imem_ack   : response valid (only meaningful while imem_req=1)
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch unit, slave = instruction memory.
interface ifetc32_mc_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifetc32_mc.sv
// ifetc32_mc: multi-cycle instruction fetch unit.
// Owns the PC, fetches one word per instruction over a req/ack handshake,
// issues it to decode for one or more cycles (stretched by hold) and
// resolves the next PC from the control/ALU results on the ISSUE exit edge.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   imem             : instruction memory handshake (master side)
//   hold             : downstream stall while issuing
//   Branch..Jrn,Zero : control / ALU results for next-PC selection
//   Addr_result      : branch target, Read_data_1 : jr target
//   Instruction, instr_valid, PC_out, branch_base_addr, link_addr : to core
module ifetc32_mc #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  ifetc32_mc_if.master imem,
  input  logic        hold,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jrn,
  input  logic        Zero,
  input  logic [31:0] Addr_result,
  input  logic [31:0] Read_data_1,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] PC_out,
  output logic [31:0] branch_base_addr,
  output logic [31:0] link_addr
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_e;

  state_e      state_q;
  logic [31:0] pc_q, instr_q, link_q;
  logic        valid_q, req_q;
  logic [31:0] next_pc_d;
  logic        taken;

  assign branch_base_addr = pc_q + 32'd4;  // wraps modulo 2^32
  assign taken            = (Branch & Zero) | (nBranch & ~Zero);

  // Next-PC priority: jr > j/jal > taken branch > sequential.
  // Register targets are masked to word alignment.
  always_comb begin
    next_pc_d = branch_base_addr;
    if (Jrn)
      next_pc_d = Read_data_1 & ~32'h3;
    else if (Jmp || Jal)
      next_pc_d = {branch_base_addr[31:28], instr_q[25:0], 2'b00};
    else if (taken)
      next_pc_d = Addr_result & ~32'h3;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      link_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          // acks landing here (e.g. stragglers from before reset) are dropped
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            state_q <= ISSUE;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (!hold) begin
            pc_q    <= next_pc_d;
            if (Jal) link_q <= branch_base_addr;
            state_q <= FETCH;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign Instruction    = instr_q;
  assign instr_valid    = valid_q;
  assign PC_out         = pc_q;
  assign link_addr      = link_q;

endmodule
